// File: rtl/ept_xlate_sched_pkg.sv
// Shared types for the EPT translation scheduler: FSM encoding and the latched
// request payload.
package ept_pkg;

    localparam int VMID_W = 8;
    localparam int PA_W   = 64;

    typedef enum logic [1:0] {
        EPT_IDLE,
        EPT_XLATE,
        EPT_RESP
    } ept_sched_state_e;

    typedef struct packed {
        logic [VMID_W-1:0] vmid;
        logic [PA_W-1:0]   gpa;
    } ept_req_t;

endpackage

// File: rtl/ept_xlate_sched_arb.sv
// Combinational round-robin arbiter: grants the first request found searching
// upward from last_i+1 with wrap at N-1. The pointer itself lives in the parent.
module rr_arbiter #(
    parameter int N    = 3,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] last_i,
    input  logic            enable_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] gnt_id_o
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = last_i;
        for (int i = 0; i < N; i++) begin
            idx = (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
            if (enable_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/ept_xlate_sched.sv
// Shares one combinational EPT port among NUM_REQ requesters: arbitrate, drive
// the EPT for one cycle, gate the result by the per-VM enable table, respond.
module ept_xlate_sched
    import ept_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*VMID_W-1:0] req_vmid_i,
    input  logic [NUM_REQ*PA_W-1:0]   req_gpa_i,
    output logic                      ept_valid_o,
    output logic [VMID_W-1:0]         ept_vmid_o,
    output logic [PA_W-1:0]           ept_gpa_o,
    input  logic [PA_W-1:0]           ept_hpa_i,
    input  logic                      ept_fault_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [ID_W-1:0]           resp_id_o,
    output logic [PA_W-1:0]           resp_hpa_o,
    output logic                      resp_fault_o,
    input  logic                      vm_en_we_i,
    input  logic [VMID_W-1:0]         vm_en_idx_i,
    input  logic                      vm_en_val_i,
    output logic                      busy_o
);

    ept_sched_state_e state_q, state_d;
    logic [ID_W-1:0]  rr_last_q, rr_last_d;
    logic [ID_W-1:0]  id_q, id_d;
    ept_req_t         req_q, req_d, win_req;
    logic [PA_W-1:0]  hpa_q, hpa_d;
    logic             fault_q, fault_d;
    logic [255:0]     vm_en_q;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i    (req_valid_i),
        .last_i   (rr_last_q),
        .enable_i (state_q == EPT_IDLE),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    always_comb begin
        win_req = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                win_req.vmid = req_vmid_i[VMID_W*k +: VMID_W];
                win_req.gpa  = req_gpa_i[PA_W*k +: PA_W];
            end
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        id_d      = id_q;
        req_d     = req_q;
        hpa_d     = hpa_q;
        fault_d   = fault_q;
        unique case (state_q)
            EPT_IDLE: begin
                if (|gnt) begin
                    req_d     = win_req;
                    id_d      = gnt_id;
                    rr_last_d = gnt_id;
                    state_d   = EPT_XLATE;
                end
            end
            EPT_XLATE: begin
                // vm_en_q still holds the pre-write value for a same-cycle write.
                fault_d = ept_fault_i | ~vm_en_q[req_q.vmid];
                hpa_d   = fault_d ? '0 : ept_hpa_i;
                state_d = EPT_RESP;
            end
            EPT_RESP: begin
                if (resp_ready_i) state_d = EPT_IDLE;
            end
            default: state_d = EPT_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EPT_IDLE;
            rr_last_q <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            req_q     <= '0;
            hpa_q     <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            id_q      <= id_d;
            req_q     <= req_d;
            hpa_q     <= hpa_d;
            fault_q   <= fault_d;
        end
    end

    // NOTE: this table is a flop array, not a RAM macro, so it is reset; only
    // VMID 0 comes up enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vm_en_q <= 256'h1;
        end else if (vm_en_we_i) begin
            vm_en_q[vm_en_idx_i] <= vm_en_val_i;
        end
    end

    assign req_ready_o  = gnt;
    assign ept_valid_o  = (state_q == EPT_XLATE);
    assign ept_vmid_o   = ept_valid_o ? req_q.vmid : '0;
    assign ept_gpa_o    = ept_valid_o ? req_q.gpa : '0;
    assign resp_valid_o = (state_q == EPT_RESP);
    assign resp_id_o    = id_q;
    assign resp_hpa_o   = hpa_q;
    assign resp_fault_o = fault_q;
    assign busy_o       = (state_q != EPT_IDLE);

endmodule

// File: doc/ept_xlate_sched.md
Name: ept_xlate_sched

Overview:
Shares one EPT translation port among NUM_REQ requesters, such as the ITLB miss path, the DTLB miss path and the page walker. Round-robin arbitration picks one request, sequences it through the combinational EPT, gates the result against a per-VM enable table, and returns the response with the requester ID. It sits between the TLB miss logic and the `ept` instance in the virtualization subsystem.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
req_vmid_i  in  NUM_REQ*8  packed VMIDs, requester k at [8k+7:8k]
req_gpa_i  in  NUM_REQ*64  packed guest physical addresses
ept_valid_o  out  1  drives the EPT translate_valid_i
ept_vmid_o  out  8  drives the EPT vmid_i
ept_gpa_o  out  64  drives the EPT gpa_i
ept_hpa_i  in  64  EPT hpa_o
ept_fault_i  in  1  EPT fault_o
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumer ready
resp_id_o  out  ID_W  index of the requester being answered
resp_hpa_o  out  64  host physical address; 0 on fault
resp_fault_o  out  1  translation fault
vm_en_we_i  in  1  VM-enable table write strobe
vm_en_idx_i  in  8  VMID to write
vm_en_val_i  in  1  enable value
busy_o  out  1  high when the FSM is not IDLE

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state = IDLE; all outputs 0.
  - rr_last = NUM_REQ-1, so requester 0 has first priority.
  - Latched vmid/gpa/hpa/fault/id = 0.
  - vm_en = 256'h1 (only VMID 0 enabled).
- FSM states: IDLE, XLATE, RESP.
- IDLE:
  - If any req_valid_i is set, grant the first set bit searching upward from rr_last+1 modulo NUM_REQ.
  - req_ready_o[winner] = 1 combinationally in this cycle; the transfer occurs here.
  - Latch vmid, gpa and id; set rr_last = winner; go to XLATE.
  - If no request is valid, req_ready_o = 0 and the FSM stays in IDLE.
- XLATE:
  - ept_valid_o = 1; ept_vmid_o and ept_gpa_o come from the latched values. Outside XLATE, all ept_* outputs are 0.
  - Capture the result:
    - fault_q = ept_fault_i | ~vm_en[vmid_q].
    - hpa_q = fault_q ? 0 : ept_hpa_i.
  - Go to RESP unconditionally.
- RESP:
  - resp_valid_o = 1; resp_id_o, resp_hpa_o and resp_fault_o are held stable from registers.
  - On resp_ready_i = 1, go to IDLE. Otherwise hold.
  - resp_valid_o is 0 in all other states.
- Latency: accept in cycle N, EPT access in N+1, resp_valid_o first high in N+2. Maximum throughput is one request per 3 cycles. req_ready_o is never high outside IDLE.
- Requests are not required to stay valid until granted, but the bench keeps them asserted. Non-granted requesters see ready = 0 and retry.
- VM-enable table:
  - Write occurs at the clock edge when vm_en_we_i = 1, in any state.
  - A write landing in the same cycle as XLATE for the same VMID does not affect that translation; the old value is used. The new value applies from the next cycle.
- Mid-operation reset returns to IDLE immediately. Any in-flight request is dropped with no response.
- All vmid values 0..255 are legal; there is no out-of-range case. Round-robin wrap goes from NUM_REQ-1 to 0.

Decomposition:
- Package ept_pkg:
  - typedef enum logic [1:0] {EPT_IDLE, EPT_XLATE, EPT_RESP} ept_sched_state_e.
  - typedef struct packed {logic [7:0] vmid; logic [63:0] gpa;} ept_req_t.
  - localparam VMID_W = 8, PA_W = 64.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], last[ID_W], enable.
  - Outputs: one-hot gnt[N], gnt_id.
  - Purely combinational; rr_last is stored in the parent.

Test Plan:
- Single request: EPT key for VMID 0 = 64'h0, vm_en reset value.
  - Stimulus: req0 with vmid 0, gpa 64'h1000.
  - Required: ready0 in cycle 0, ept_valid_o in cycle 1, resp in cycle 2 with id 0, hpa 64'h1000, fault 0.
- Round-robin: all three requesters held valid.
  - Required: grants in order 0, 1, 2, 0, with successive grants 3 cycles apart while resp_ready_i = 1.
  - Then drop req1; required grant order continues 2, 0, 2.
- Disabled VM: req1 with vmid 5 while vm_en[5] = 0.
  - Required: resp_fault_o = 1 and resp_hpa_o = 0.
  - Then write vm_en[5] = 1 with EPT key[5] = 64'hFF00 and repeat gpa 64'h00AB.
  - Required: hpa 64'hFFAB, fault 0.
- Backpressure: hold resp_ready_i = 0 for 5 cycles in RESP.
  - Required: resp outputs stable, req_ready_o all 0, busy_o = 1.
  - On release: IDLE on the next cycle.
- Write collision: in the XLATE cycle for vmid 3 (enabled), write vm_en[3] = 0.
  - Required: that response has fault 0; the next vmid 3 request faults.
- Reset mid-operation: assert rst_n = 0 during XLATE.
  - Required: all outputs 0 and no response issued.
  - After release, req2 is granted ahead of req0 only if req0 is not valid; rr_last is back to NUM_REQ-1.
